// File: rtl/zigzag_pkg.sv
// rtl/zigzag_pkg.sv - shared constants for the zig-zag reorder controller
// Contents: COEF_PER_BLK (coefficients per 8x8 block), IDX_W (coefficient
// index width), ZZ_LUT (zig-zag position -> raster index).
package zigzag_pkg;

  localparam int COEF_PER_BLK = 64;
  localparam int IDX_W        = 6;

  // Entry n is the raster index (row*8+col) of the n-th zig-zag coefficient.
  localparam logic [IDX_W-1:0] ZZ_LUT [0:COEF_PER_BLK-1] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

endpackage

// File: rtl/zigzag_ctrl_side.sv
// rtl/zigzag_ctrl_side.sv - bank pointer plus coefficient counter for one side
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_flush    : synchronous clear of pointer and counter
//   i_step     : one coefficient moved on this side this cycle
//   o_bank     : bank currently addressed by this side
//   o_cnt      : coefficient index within the current block
//   o_wrap     : this step finishes the block (suppressed during flush)
module zigzag_ctrl_side
  import zigzag_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_step,
  output logic             o_bank,
  output logic [IDX_W-1:0] o_cnt,
  output logic             o_wrap
);

  logic             r_bank;
  logic [IDX_W-1:0] r_cnt;
  logic             w_at_end;

  assign w_at_end = (r_cnt == IDX_W'(COEF_PER_BLK - 1));
  assign o_wrap   = i_step && w_at_end && !i_flush;
  assign o_bank   = r_bank;
  assign o_cnt    = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank <= 1'b0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_bank <= 1'b0;
      r_cnt  <= '0;
    end else if (i_step) begin
      // 64 entries exactly fill the counter, so 63 -> 0 wraps naturally.
      r_cnt <= r_cnt + 1'b1;
      if (w_at_end) begin
        r_bank <= ~r_bank;
      end
    end
  end

endmodule

// File: rtl/zigzag_ctrl.sv
// rtl/zigzag_ctrl.sv - ping-pong sequencing controller for zig-zag reorder
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous abort of all buffered/partial blocks
//   in_valid / in_ready : raster-order coefficient handshake
//   wr_en, wr_bank, wr_addr : coefficient bank write controls
//   out_valid / out_ready   : zig-zag coefficient handshake
//   rd_bank, rd_addr, out_last : bank read mux controls, last-of-block flag
//   blk_cnt             : completed (fully drained) blocks, wrapping
module zigzag_ctrl
  import zigzag_pkg::*;
#(
  parameter int BLK_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic                 wr_bank,
  output logic [IDX_W-1:0]     wr_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 rd_bank,
  output logic [IDX_W-1:0]     rd_addr,
  output logic                 out_last,
  output logic [BLK_CNT_W-1:0] blk_cnt
);

  logic [1:0]           r_full;
  logic [BLK_CNT_W-1:0] r_blk_cnt;
  logic [1:0]           w_full_nxt;

  logic                 w_accept;
  logic                 w_xfer;
  logic                 w_wr_bank;
  logic                 w_rd_bank;
  logic [IDX_W-1:0]     w_wr_cnt;
  logic [IDX_W-1:0]     w_rd_cnt;
  logic                 w_wr_wrap;
  logic                 w_rd_wrap;

  // Writer only sees banks that are not full, reader only full ones, so the
  // two sides can never collide on a bank in the same role.
  assign in_ready  = !r_full[w_wr_bank];
  assign out_valid = r_full[w_rd_bank];
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = out_valid && out_ready;

  assign wr_en     = w_accept;
  assign wr_bank   = w_wr_bank;
  assign wr_addr   = w_wr_cnt;
  assign rd_bank   = w_rd_bank;
  assign rd_addr   = out_valid ? ZZ_LUT[w_rd_cnt] : ZZ_LUT[0];
  assign out_last  = out_valid && (w_rd_cnt == IDX_W'(COEF_PER_BLK - 1));
  assign blk_cnt   = r_blk_cnt;

  zigzag_ctrl_side u_wr_side (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_step  (w_accept),
    .o_bank  (w_wr_bank),
    .o_cnt   (w_wr_cnt),
    .o_wrap  (w_wr_wrap)
  );

  zigzag_ctrl_side u_rd_side (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_step  (w_xfer),
    .o_bank  (w_rd_bank),
    .o_cnt   (w_rd_cnt),
    .o_wrap  (w_rd_wrap)
  );

  // Final write and final read land on different banks, so both flag updates
  // can be applied in the same cycle without arbitration.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_wrap) begin
      w_full_nxt[w_wr_bank] = 1'b1;
    end
    if (w_rd_wrap) begin
      w_full_nxt[w_rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full    <= 2'b00;
      r_blk_cnt <= '0;
    end else if (flush) begin
      // Block count survives a flush; only buffered data is discarded.
      r_full    <= 2'b00;
    end else begin
      r_full    <= w_full_nxt;
      if (w_rd_wrap) begin
        r_blk_cnt <= r_blk_cnt + 1'b1;
      end
    end
  end

endmodule
